// File: rtl/mod_exp_ctrl.sv
// mod_exp_ctrl: left-to-right square-and-multiply sequencer for M^e mod n.
// Drives the Montgomery-product stage with square (OPXX), multiply-by-M_bar
// (OPXM) and final conversion (OPX1) operations and captures the result.
module mod_exp_ctrl #(
    parameter int EBITS     = 256,
    parameter int LOG_EBITS = 8,
    parameter int BITLEN    = 256,
    parameter int MP_COUNT  = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [EBITS-1:0]     e,
    input  logic [LOG_EBITS:0]   e_len,
    output logic                 mp_start,
    output logic [1:0]           mp_op_code,
    output logic [LOG_EBITS:0]   mp_count,
    input  logic                 mp_stop,
    input  logic [BITLEN:0]      mp_P,
    output logic                 busy,
    output logic                 done,
    output logic [BITLEN-1:0]    result
);

    // The stage has no reset, so after our reset we wait long enough for any
    // operation it was running to drain before accepting work.
    localparam int FLUSH_CYCLES = MP_COUNT + 4;
    localparam int FW           = $clog2(FLUSH_CYCLES + 1);

    localparam logic [1:0] OPXX = 2'd0;
    localparam logic [1:0] OPXM = 2'd1;
    localparam logic [1:0] OPX1 = 2'd2;

    localparam logic [LOG_EBITS:0] IDX_ONE   = 1;
    localparam logic [FW-1:0]      FLUSH_ONE = 1;
    localparam logic [FW-1:0]      FLUSH_END = FW'(FLUSH_CYCLES - 1);

    typedef enum logic [2:0] {
        S_FLUSH,
        S_IDLE,
        S_NEXT,
        S_ISSUE,
        S_ARM,
        S_WAIT
    } state_t;

    state_t              state_q,     state_d;
    logic [FW-1:0]       flush_cnt_q, flush_cnt_d;
    logic [EBITS-1:0]    e_q,         e_d;
    logic [LOG_EBITS:0]  idx_q,       idx_d;
    logic [1:0]          op_q,        op_d;
    logic                mp_start_q,  mp_start_d;
    logic                busy_q,      busy_d;
    logic                done_q,      done_d;
    logic [BITLEN-1:0]   result_q,    result_d;

    // Only the low BITLEN bits of the stage result form the final value.
    logic mp_p_msb_unused;
    assign mp_p_msb_unused = mp_P[BITLEN];

    assign mp_start   = mp_start_q;
    assign mp_op_code = op_q;
    assign mp_count   = (LOG_EBITS + 1)'(MP_COUNT);
    assign busy       = busy_q;
    assign done       = done_q;
    assign result     = result_q;

    // Next-state logic: each transition into ISSUE also raises mp_start so the
    // pulse is registered and lines up exactly with the ISSUE cycle.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        e_d         = e_q;
        idx_d       = idx_q;
        op_d        = op_q;
        mp_start_d  = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        result_d    = result_q;

        case (state_q)
            S_FLUSH: begin
                busy_d = 1'b1;
                if (flush_cnt_q == FLUSH_END) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    flush_cnt_d = flush_cnt_q + FLUSH_ONE;
                end
            end
            S_IDLE: begin
                // The cycle where done is high still belongs to the finishing
                // operation, so a start there is not taken.
                if (start && !done_q) begin
                    e_d     = e;
                    idx_d   = e_len;
                    busy_d  = 1'b1;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (idx_q == '0) begin
                    op_d = OPX1;
                end else begin
                    idx_d = idx_q - IDX_ONE;
                    op_d  = OPXX;
                end
                mp_start_d = 1'b1;
                state_d    = S_ISSUE;
            end
            S_ISSUE: begin
                state_d = S_ARM;
            end
            S_ARM: begin
                // mp_stop may still be high from the previous op here.
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mp_stop) begin
                    case (op_q)
                        OPXX: begin
                            if (e_q[idx_q[LOG_EBITS-1:0]]) begin
                                op_d       = OPXM;
                                mp_start_d = 1'b1;
                                state_d    = S_ISSUE;
                            end else begin
                                state_d = S_NEXT;
                            end
                        end
                        OPXM: begin
                            state_d = S_NEXT;
                        end
                        default: begin
                            result_d = mp_P[BITLEN-1:0];
                            done_d   = 1'b1;
                            busy_d   = 1'b0;
                            state_d  = S_IDLE;
                        end
                    endcase
                end
            end
            default: begin
                state_d = S_FLUSH;
            end
        endcase
    end

    // State and registered outputs; reset forces a full flush on release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_FLUSH;
            flush_cnt_q <= '0;
            e_q         <= '0;
            idx_q       <= '0;
            op_q        <= OPXX;
            mp_start_q  <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            e_q         <= e_d;
            idx_q       <= idx_d;
            op_q        <= op_d;
            mp_start_q  <= mp_start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            result_q    <= result_d;
        end
    end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// tb_mod_exp_ctrl: drives mod_exp_ctrl against a small Montgomery-stage model
// working modulo 61 with R = 2^256, and checks op sequences and results.
module tb_mod_exp_ctrl;

    localparam int EBITS        = 256;
    localparam int LOG_EBITS    = 8;
    localparam int BITLEN       = 256;
    localparam int MP_COUNT     = 256;
    localparam int FLUSH_CYCLES = MP_COUNT + 4;
    localparam int N_MOD        = 61;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic [EBITS-1:0]    e;
    logic [LOG_EBITS:0]  e_len;
    logic                mp_start;
    logic [1:0]          mp_op_code;
    logic [LOG_EBITS:0]  mp_count;
    logic                mp_stop = 1'b1;
    logic [BITLEN:0]     mp_P = '0;
    logic                busy;
    logic                done;
    logic [BITLEN-1:0]   result;

    int errors = 0;
    int checks = 0;
    int start_count = 0;
    int done_count = 0;

    int exp_ops[$];
    logic [BITLEN-1:0] exp_result = '0;
    int r_mod = 1;
    int r_inv = 0;

    // Montgomery stage model state
    logic       stage_busy = 1'b0;
    int         stage_cnt = 0;
    logic [1:0] stage_op = 2'd0;
    int         op_seq = 0;
    int         x_mem = 0;
    int         m_bar = 0;
    int         stage_p = 0;
    logic       load_pulse = 1'b0;
    int         load_x = 0;
    int         load_mbar = 0;

    mod_exp_ctrl #(
        .EBITS(EBITS), .LOG_EBITS(LOG_EBITS), .BITLEN(BITLEN), .MP_COUNT(MP_COUNT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .e(e), .e_len(e_len),
        .mp_start(mp_start), .mp_op_code(mp_op_code), .mp_count(mp_count),
        .mp_stop(mp_stop), .mp_P(mp_P), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    function automatic int mont(input int a, input int b);
        return (((a * b) % N_MOD) * r_inv) % N_MOD;
    endfunction

    // Right-to-left binary exponentiation in the normal domain.
    function automatic int modexp(input int m, input logic [EBITS-1:0] ev, input int len);
        int r = 1;
        int b = m % N_MOD;
        for (int i = 0; i < len; i++) begin
            if (ev[i]) r = (r * b) % N_MOD;
            b = (b * b) % N_MOD;
        end
        return r;
    endfunction

    task automatic check_output(input string name, input logic [BITLEN:0] actual,
                                input logic [BITLEN:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Stage model: one op per mp_start, variable latency, result written back to x.
    always @(posedge clk) begin
        if (load_pulse) begin
            x_mem <= load_x;
            m_bar <= load_mbar;
        end
        if (mp_start) begin
            stage_busy <= 1'b1;
            stage_op   <= mp_op_code;
            stage_cnt  <= op_seq % 4;
            op_seq     <= op_seq + 1;
            mp_stop    <= 1'b0;
        end else if (stage_busy) begin
            if (stage_cnt == 0) begin
                case (stage_op)
                    2'd0:    stage_p = mont(x_mem, x_mem);
                    2'd1:    stage_p = mont(x_mem, m_bar);
                    default: stage_p = mont(x_mem, 1);
                endcase
                x_mem      <= stage_p;
                mp_P       <= {1'b1, BITLEN'(stage_p)};
                mp_stop    <= 1'b1;
                stage_busy <= 1'b0;
            end else begin
                stage_cnt <= stage_cnt - 1;
            end
        end
    end

    // Compare process: every issued op against the expected sequence, op-code
    // stability while the stage works, and the result on every done pulse.
    always @(negedge clk) begin
        if (!reset) begin
            if (mp_start) begin
                start_count++;
                check_output("mp_stop_high_at_issue", mp_stop, 1);
                if (exp_ops.size() == 0)
                    check_output("unexpected_mp_start", mp_start, 0);
                else
                    check_output("op_code", mp_op_code, exp_ops.pop_front());
            end else if (stage_busy) begin
                check_output("op_code_stable", mp_op_code, stage_op);
            end
            if (done) begin
                done_count++;
                check_output("result", result, exp_result);
                check_output("busy_at_done", busy, 0);
                check_output("ops_left_at_done", exp_ops.size(), 0);
            end
        end
    end

    task automatic build_expectation(input logic [EBITS-1:0] ev, input int len, input int m);
        for (int i = len - 1; i >= 0; i--) begin
            exp_ops.push_back(0);
            if (ev[i]) exp_ops.push_back(1);
        end
        exp_ops.push_back(2);
        exp_result = BITLEN'(modexp(m, ev, len));
        load_x     = r_mod;
        load_mbar  = ((m % N_MOD) * r_mod) % N_MOD;
        load_pulse = 1'b1;
    endtask

    // Preload the stage, pulse start, then scramble e/e_len to prove they were latched.
    task automatic apply_stimulus(input logic [EBITS-1:0] ev, input int len, input int m);
        @(negedge clk);
        build_expectation(ev, len, m);
        @(negedge clk);
        load_pulse = 1'b0;
        e     = ev;
        e_len = (LOG_EBITS + 1)'(len);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e     = ~ev;
        e_len = 9'd200;
        check_output("issue_latency_early", mp_start, 0);
        @(negedge clk);
        check_output("issue_latency", mp_start, 1);
    endtask

    task automatic wait_done(input int budget, input bit spam);
        bit seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (spam) start = (c % 5 == 2);
        end
        if (!seen) check_output("done_timeout", done, 1);
    endtask

    task automatic flush_check();
        for (int i = 1; i <= FLUSH_CYCLES; i++) begin
            @(posedge clk);
            #1;
            start = (i == 10);
            if (i == FLUSH_CYCLES - 1) check_output("busy_in_flush", busy, 1);
            if (i == FLUSH_CYCLES)     check_output("idle_after_flush", busy, 0);
        end
        start = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_busy"}, busy, 1);
        check_output({tag, "_done"}, done, 0);
        check_output({tag, "_mp_start"}, mp_start, 0);
        check_output({tag, "_mp_op_code"}, mp_op_code, 0);
        check_output({tag, "_result"}, result, 0);
        check_output({tag, "_mp_count"}, mp_count, MP_COUNT);
    endtask

    int s0, d0;
    bit prev_low, found;

    initial begin
        repeat (256) r_mod = (r_mod * 2) % N_MOD;
        for (int k = 1; k < N_MOD; k++)
            if ((r_mod * k) % N_MOD == 1) r_inv = k;

        reset = 1'b1; start = 1'b0; e = '0; e_len = '0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;
        flush_check();

        // e=13, e_len=4, M=7: 8 ops, 7^13 mod 61 = 55
        s0 = start_count; d0 = done_count;
        apply_stimulus(EBITS'(13), 4, 7);
        wait_done(2000, 1'b0);
        @(negedge clk);
        check_output("done_single_cycle", done, 0);
        check_output("result_e13", result, 55);
        check_output("ops_e13", start_count - s0, 8);
        check_output("dones_e13", done_count - d0, 1);
        check_output("busy_after_e13", busy, 0);

        // e_len=0: only the conversion op, result 1
        s0 = start_count;
        apply_stimulus(EBITS'(255), 0, 7);
        wait_done(2000, 1'b0);
        @(negedge clk);
        check_output("result_len0", result, 1);
        check_output("ops_len0", start_count - s0, 1);

        // all-ones exponent over the full width
        s0 = start_count;
        apply_stimulus({EBITS{1'b1}}, EBITS, 3);
        wait_done(20000, 1'b0);
        @(negedge clk);
        check_output("ops_all_ones", start_count - s0, 513);

        // start spammed during a run and coincident with done; next cycle accepted
        s0 = start_count; d0 = done_count;
        apply_stimulus(EBITS'(13), 4, 5);
        wait_done(2000, 1'b1);
        start = 1'b1; e = EBITS'(5); e_len = 9'd3;
        @(negedge clk);
        check_output("start_at_done_ignored", busy, 0);
        check_output("ops_spam", start_count - s0, 8);
        check_output("dones_spam", done_count - d0, 1);
        s0 = start_count;
        build_expectation(EBITS'(5), 3, 7);
        @(negedge clk);
        start = 1'b0; load_pulse = 1'b0;
        check_output("start_after_done_accepted", busy, 1);
        wait_done(2000, 1'b0);
        @(negedge clk);
        check_output("result_back_to_back", result, 32);
        check_output("ops_back_to_back", start_count - s0, 6);

        // reset while waiting on the stage
        apply_stimulus({EBITS{1'b1}}, EBITS, 7);
        repeat (50) @(negedge clk);
        prev_low = 1'b0; found = 1'b0;
        for (int c = 0; c < 500 && !found; c++) begin
            @(negedge clk);
            if (!mp_stop && prev_low) found = 1'b1;
            prev_low = !mp_stop;
        end
        if (!found) check_output("reach_wait", mp_stop, 0);
        #2 reset = 1'b1;
        #1 check_reset_values("mid_reset");
        exp_ops.delete();
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        flush_check();

        s0 = start_count;
        apply_stimulus(EBITS'(5), 3, 7);
        wait_done(2000, 1'b0);
        @(negedge clk);
        check_output("result_after_reset", result, 32);
        check_output("ops_after_reset", start_count - s0, 6);

        // bits at or above e_len are ignored
        s0 = start_count;
        apply_stimulus(EBITS'(64'h1_0000_0005), 3, 7);
        wait_done(2000, 1'b0);
        @(negedge clk);
        check_output("result_upper_ignored", result, 32);
        check_output("ops_upper_ignored", start_count - s0, 6);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
